// File: rtl/host_uart_command_dec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : host_uart_command_dec
//  Purpose  : Decodes one host command frame from the UART receive buffer into
//             a one-hot command select and a decoded argument word. Frame
//             format and command ID are checked; rejected frames raise error.
//  Frame    : byte0 = command ID, bytes1..6 = 48-bit target address,
//             SET_ENCRYPT adds byte7 = payload size and byte8 = payload.
//  Ports    : clk          rising-edge system clock
//             reset        asynchronous, active-low reset
//             input_data   command frame buffer, byte 0 in bits [7:0]
//             start        decode request, level-sampled while idle
//             output_data  decoded argument word
//             done         one-cycle pulse when a decode finishes
//             error        qualifies done: frame rejected
//             cmd_select   one-hot command, bit n = command ID n
//  Config   : HOST_UART_DEC_STRICT_EN - when defined, any set bit above the
//             frame (bit 72 up for SET_ENCRYPT, bit 56 up for READ_*) rejects
//             the frame; when undefined those bits are ignored.
//  Revision : 1.0 - initial release
// ============================================================================
module host_uart_command_dec #(
  parameter int IN_W  = 1024,
  parameter int OUT_W = 256,
  parameter int SEL_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IN_W-1:0]  input_data,
  input  logic             start,
  output logic [OUT_W-1:0] output_data,
  output logic             done,
  output logic             error,
  output logic [SEL_W-1:0] cmd_select
);

  localparam logic [7:0]  c_id_set_encrypt = 8'h01;
  localparam logic [7:0]  c_id_read_roll   = 8'h02;
  localparam logic [7:0]  c_id_read_yaw    = 8'h03;
  localparam logic [7:0]  c_id_read_pitch  = 8'h04;
  localparam logic [47:0] c_bcast_target   = 48'hFFFF_FFFF_FFFF;
  localparam logic [7:0]  c_enc_size       = 8'h01;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DECODE  = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_next;

  // Captured frame and the fields split out of it during CAPTURE
  logic [IN_W-1:0]  r_frame;
  logic [7:0]       r_id;
  logic [47:0]      r_target;
  logic [7:0]       r_size;
  logic [7:0]       r_payload;

  // Decode results and registered outputs
  logic             w_err;
  logic [SEL_W-1:0] w_sel;
  logic [OUT_W-1:0] w_out;
  logic             w_done;
  logic             r_err;
  logic [SEL_W-1:0] r_sel;
  logic [OUT_W-1:0] r_out;

`ifdef HOST_UART_DEC_STRICT_EN
  // Non-zero flags for the bits beyond each frame format
  logic r_hi72_nz;
  logic r_hi56_nz;
`else
  // Bits beyond the longest frame play no part in the relaxed decode
  logic w_unused_hi;
  assign w_unused_hi = |r_frame[IN_W-1:72];
`endif

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next state and done strobe; start only matters in IDLE so a long start
  // level yields exactly one decode per IDLE visit.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_done       = 1'b0;
    case (r_state)
      ST_IDLE:    if (start) w_state_next = ST_CAPTURE;
      ST_CAPTURE: w_state_next = ST_DECODE;
      ST_DECODE:  w_state_next = ST_DONE;
      ST_DONE: begin
        w_done       = 1'b1;
        w_state_next = ST_IDLE;
      end
      default:    w_state_next = ST_IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // Frame capture on an accepted start, then field split in CAPTURE
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_frame   <= '0;
      r_id      <= '0;
      r_target  <= '0;
      r_size    <= '0;
      r_payload <= '0;
`ifdef HOST_UART_DEC_STRICT_EN
      r_hi72_nz <= 1'b0;
      r_hi56_nz <= 1'b0;
`endif
    end else begin
      if (r_state == ST_IDLE && start) begin
        r_frame <= input_data;
      end
      if (r_state == ST_CAPTURE) begin
        r_id      <= r_frame[7:0];
        r_target  <= r_frame[55:8];
        r_size    <= r_frame[63:56];
        r_payload <= r_frame[71:64];
`ifdef HOST_UART_DEC_STRICT_EN
        r_hi72_nz <= |r_frame[IN_W-1:72];
        r_hi56_nz <= |r_frame[IN_W-1:56];
`endif
      end
    end
  end

  // --------------------------------------------------------------------------
  // Command decode and validity checks
  // --------------------------------------------------------------------------
  always_comb begin
    w_err = 1'b0;
    w_sel = '0;
    w_out = '0;
    case (r_id)
      c_id_set_encrypt: begin
        if (r_target != c_bcast_target)  w_err = 1'b1;
        if (r_size != c_enc_size)        w_err = 1'b1;
        if (r_payload[7:1] != 7'd0)      w_err = 1'b1;
`ifdef HOST_UART_DEC_STRICT_EN
        if (r_hi72_nz)                   w_err = 1'b1;
`endif
        w_sel[r_id[3:0]] = 1'b1;
        w_out[7:0]       = r_payload;
      end
      c_id_read_roll, c_id_read_yaw, c_id_read_pitch: begin
`ifdef HOST_UART_DEC_STRICT_EN
        if (r_hi56_nz)                   w_err = 1'b1;
`endif
        w_sel[r_id[3:0]] = 1'b1;
        w_out[47:0]      = r_target;
      end
      default: w_err = 1'b1;
    endcase
    // A rejected frame reports no command and no argument
    if (w_err) begin
      w_sel = '0;
      w_out = '0;
    end
  end

  // --------------------------------------------------------------------------
  // Result registers: loaded on the DECODE->DONE edge so they are valid with
  // done and hold until the next decode completes.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err <= 1'b0;
      r_sel <= '0;
      r_out <= '0;
    end else if (r_state == ST_DECODE) begin
      r_err <= w_err;
      r_sel <= w_sel;
      r_out <= w_out;
    end
  end

  assign done        = w_done;
  assign error       = w_done & r_err;
  assign cmd_select  = r_sel;
  assign output_data = r_out;

endmodule
`default_nettype wire

// File: tb/tb_host_uart_command_dec.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_host_uart_command_dec
//  Purpose  : Self-checking bench for host_uart_command_dec. Directed frames
//             plus randomized frames compared against a behavioural model of
//             the frame rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_host_uart_command_dec;

  logic           clk;
  logic           reset;
  logic [1023:0]  input_data;
  logic           start;
  logic [255:0]   output_data;
  logic           done;
  logic           error;
  logic [15:0]    cmd_select;

  int errors = 0;
  int checks = 0;

  host_uart_command_dec #(
    .IN_W  (1024),
    .OUT_W (256),
    .SEL_W (16)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .input_data  (input_data),
    .start       (start),
    .output_data (output_data),
    .done        (done),
    .error       (error),
    .cmd_select  (cmd_select)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Behavioural reference: frame rules applied to the raw frame value
  function automatic void model(input logic [1023:0] f, output logic e,
                                output logic [15:0] s, output logic [255:0] o);
    int unsigned id;
    logic [47:0] target;
    int unsigned size;
    int unsigned pay;
    bit strict;
    bit ok;
    id     = f[7:0];
    target = f[55:8];
    size   = f[63:56];
    pay    = f[71:64];
`ifdef HOST_UART_DEC_STRICT_EN
    strict = 1'b1;
`else
    strict = 1'b0;
`endif
    if (id == 1)
      ok = (target == 48'hFFFF_FFFF_FFFF) && (size == 1) && (pay < 2) &&
           !(strict && ((f >> 72) != 0));
    else if (id >= 2 && id <= 4)
      ok = !(strict && ((f >> 56) != 0));
    else
      ok = 1'b0;
    if (ok) begin
      e = 1'b0;
      s = 16'd1 << id;
      o = (id == 1) ? 256'(pay) : 256'(target);
    end else begin
      e = 1'b1;
      s = '0;
      o = '0;
    end
  endfunction

  // Drive one frame, wait (bounded) for done, check latency and results,
  // then check the single-cycle pulse and that results hold.
  task automatic run_frame(input logic [1023:0] f, input string tag);
    logic        e;
    logic [15:0] s;
    logic [255:0] o;
    int lat;
    model(f, e, s, o);
    @(negedge clk);
    input_data = f;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat   = 1;
    while (!done && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 256'(lat), 256'd3);
    check({tag, ".done"},    256'(done), 256'd1);
    check({tag, ".error"},   256'(error), 256'(e));
    check({tag, ".sel"},     256'(cmd_select), 256'(s));
    check({tag, ".out"},     output_data, o);
    @(negedge clk);
    check({tag, ".pulse"},   256'(done), 256'd0);
    check({tag, ".hold"},    output_data, o);
  endtask

  function automatic logic [1023:0] rand_frame();
    logic [1023:0] f;
    int kind;
    for (int i = 0; i < 32; i++) f[i*32 +: 32] = $urandom;
    kind = $urandom_range(0, 6);
    case (kind)
      0: begin
        f[7:0]   = 8'h01;
        f[55:8]  = 48'hFFFF_FFFF_FFFF;
        f[63:56] = 8'h01;
        f[71:64] = 8'($urandom_range(0, 1));
      end
      1: begin
        f[7:0]   = 8'h01;
        if ($urandom_range(0, 1) == 1) f[55:8] = 48'hFFFF_FFFF_FFFF;
        f[63:56] = 8'($urandom_range(0, 2));
        f[71:64] = 8'($urandom_range(0, 3));
      end
      2, 3, 4: f[7:0] = 8'(kind);
      5:       f[7:0] = 8'($urandom_range(0, 15));
      default: ;
    endcase
    if ($urandom_range(0, 1) == 1) f[1023:72] = '0;
    return f;
  endfunction

  initial begin
    logic [1023:0] f;
    int cnt;
    reset      = 1'b0;
    start      = 1'b0;
    input_data = '0;
    #1;
    check("rst.done",  256'(done), 256'd0);
    check("rst.error", 256'(error), 256'd0);
    check("rst.sel",   256'(cmd_select), 256'd0);
    check("rst.out",   output_data, 256'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_frame(1024'h0101FFFFFFFFFFFF01, "enc_on");
    run_frame(1024'h0001FFFFFFFFFFFF01, "enc_off");
    run_frame(1024'hFF27FF27FF2703, "yaw_a");
    run_frame(1024'hFF27FF27FF2703, "yaw_b");

    // Reset while in CAPTURE: outputs clear at once, no done follows
    @(negedge clk);
    input_data = 1024'h0202FFFFFFFFFFFF04;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst.sel",  256'(cmd_select), 256'd0);
    check("midrst.out",  output_data, 256'd0);
    check("midrst.done", 256'(done), 256'd0);
    @(negedge clk);
    reset = 1'b1;
    cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("midrst.nodone", 256'(cnt), 256'd0);

    run_frame(1024'h0001FFFFFF27FFFF01, "bad_target");
    run_frame(1024'h0002FFFFFFFFFFFF01, "bad_size");
    run_frame(1024'hFF27FF27FF2705, "bad_id");
    run_frame(1024'h0301FFFFFFFFFFFF01, "bad_payload");
    run_frame(1024'h123456789ABC02, "roll");
    run_frame(1024'h00000000000004, "pitch");

    // READ_YAW with bit 100 set: rejected only in the strict build
    f = 1024'hFF27FF27FF2703;
    f[100] = 1'b1;
    run_frame(f, "yaw_hi");

    // start held across CAPTURE/DECODE is ignored; exactly one decode results
    @(negedge clk);
    input_data = 1024'hAABBCCDDEEFF02;
    start      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    repeat (8) begin
      @(negedge clk);
      if (done) cnt++;
    end
    check("hold_start.count", 256'(cnt), 256'd1);
    check("hold_start.out",   output_data, 256'hAABBCCDDEEFF);

    for (int i = 0; i < 24; i++) begin
      run_frame(rand_frame(), $sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
